// File: rtl/eb_pkg.sv
// Shared types and helpers for the elastic-buffer round-robin arbiter.
package eb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Wrapping increment over 0..n-1.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/eb_rr_pick.sv
// Rotating priority encoder: first set req bit scanning from ptr upwards with wrap.
module eb_rr_pick
  import eb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_vld
);

  always_comb begin
    int unsigned idx;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 32'(ptr);
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_vld && req[IDW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(idx);
      end
      idx = rr_next(idx, NREQ);
    end
  end

endmodule

// File: rtl/eb_rr_arbiter.sv
// Packet-aware round-robin arbiter feeding one FIFO write port through a single
// output register; a packet owner keeps the grant until its last beat.
module eb_rr_arbiter
  import eb_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NREQ   = 4,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rstf,
  input  logic [NREQ*DWIDTH-1:0] t_data,
  input  logic [NREQ-1:0]        t_last,
  input  logic [NREQ-1:0]        t_valid,
  output logic [NREQ-1:0]        t_ready,
  output logic [DWIDTH-1:0]      i_data,
  output logic                   i_last,
  output logic [IDW-1:0]         i_id,
  output logic                   i_valid,
  input  logic                   i_ready,
  output logic                   locked
);

  arb_state_t        state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    owner_q;

  logic [IDW-1:0]    pick_idx;
  logic              pick_vld;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_vld;
  logic              gnt_last;
  logic [DWIDTH-1:0] gnt_data;
  logic              accept;
  logic              xfer;

  eb_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req    (t_valid),
    .ptr    (ptr_q),
    .gnt_idx(pick_idx),
    .gnt_vld(pick_vld)
  );

  // While locked only the owner may be granted; bubbles simply stall the port.
  always_comb begin
    if (state_q == ARB_LOCKED) begin
      gnt_idx = owner_q;
      gnt_vld = t_valid[owner_q];
    end else begin
      gnt_idx = pick_idx;
      gnt_vld = pick_vld;
    end
  end

  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IDW'(k) == gnt_idx) begin
        gnt_data = t_data[k*DWIDTH +: DWIDTH];
        gnt_last = t_last[k];
      end
    end
  end

  assign accept = !i_valid || i_ready;
  // rstf gates the handshake so no beat is ever accepted while held in reset.
  assign xfer   = rstf && accept && gnt_vld;

  always_comb begin
    t_ready = '0;
    if (xfer) begin
      t_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      locked  <= 1'b0;
      i_valid <= 1'b0;
      i_data  <= '0;
      i_last  <= 1'b0;
      i_id    <= '0;
    end else begin
      if (accept) begin
        i_valid <= xfer;
        if (xfer) begin
          i_data <= gnt_data;
          i_last <= gnt_last;
          i_id   <= gnt_idx;
        end
      end
      if (xfer) begin
        if (gnt_last) begin
          state_q <= ARB_IDLE;
          locked  <= 1'b0;
          ptr_q   <= IDW'(rr_next(32'(gnt_idx), NREQ));
        end else begin
          state_q <= ARB_LOCKED;
          locked  <= 1'b1;
          owner_q <= gnt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_eb_rr_arbiter.sv
// Bench for eb_rr_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_eb_rr_arbiter;

  logic         clk = 1'b0;
  logic         rstf;
  logic [127:0] t_data;
  logic [3:0]   t_last, t_valid, t_ready;
  logic [31:0]  i_data;
  logic         i_last, i_valid, i_ready, locked;
  logic [1:0]   i_id;

  logic [23:0]  t_data3;
  logic [2:0]   t_last3, t_valid3, t_ready3;
  logic [7:0]   i_data3;
  logic         i_last3, i_valid3, i_ready3, locked3;
  logic [1:0]   i_id3;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;

  // Model state: owner < 0 means no packet in progress.
  int          m_ptr, m_own, m_xfer, m_id;
  logic        m_v, m_last;
  logic [31:0] m_data;
  logic [31:0] outq[$];
  int          idq[$];
  int          b;

  always #5 clk = ~clk;

  eb_rr_arbiter #(.DWIDTH(32), .NREQ(4)) dut4 (
    .clk(clk), .rstf(rstf), .t_data(t_data), .t_last(t_last), .t_valid(t_valid),
    .t_ready(t_ready), .i_data(i_data), .i_last(i_last), .i_id(i_id), .i_valid(i_valid),
    .i_ready(i_ready), .locked(locked)
  );

  eb_rr_arbiter #(.DWIDTH(8), .NREQ(3)) dut3 (
    .clk(clk), .rstf(rstf), .t_data(t_data3), .t_last(t_last3), .t_valid(t_valid3),
    .t_ready(t_ready3), .i_data(i_data3), .i_last(i_last3), .i_id(i_id3), .i_valid(i_valid3),
    .i_ready(i_ready3), .locked(locked3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ptr = 0; m_own = -1; m_xfer = -1; m_v = 1'b0; m_last = 1'b0; m_data = '0; m_id = 0;
  endtask

  // Inputs are already driven; check one cycle against the model, then advance a cycle.
  task automatic step();
    int g;
    logic acc;
    logic [3:0] etr;
    #1;
    g = -1;
    if (m_own >= 0) begin
      if (t_valid[m_own]) g = m_own;
    end else begin
      for (int i = 3; i >= 0; i--) if (t_valid[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
    end
    acc = !m_v || i_ready;
    etr = (acc && g >= 0) ? 4'(1 << g) : 4'b0;
    chk("t_ready", 64'(t_ready), 64'(etr));
    chk("i_valid", 64'(i_valid), 64'(m_v));
    chk("i_data", 64'(i_data), 64'(m_data));
    chk("i_last", 64'(i_last), 64'(m_last));
    chk("i_id", 64'(i_id), 64'(m_id));
    chk("locked", 64'(locked), 64'(m_own >= 0));
    if (i_valid && i_ready) begin
      outq.push_back(i_data);
      idq.push_back(int'(i_id));
    end
    m_xfer = -1;
    if (acc) begin
      m_v = (g >= 0);
      if (g >= 0) begin
        m_data = t_data[g*32 +: 32];
        m_last = t_last[g];
        m_id   = g;
        m_xfer = g;
        if (t_last[g]) begin
          m_own = -1;
          m_ptr = (g + 1) % 4;
        end else begin
          m_own = g;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstf = 1'b0; t_valid = '0; t_valid3 = '0;
    #1;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rstf = 1'b1;
  endtask

  initial begin
    rstf = 1'b1; t_valid = '0; t_last = '0; t_data = '0; i_ready = 1'b1;
    t_valid3 = '0; t_last3 = '0; t_data3 = 24'h332211; i_ready3 = 1'b1;
    m_reset();

    // Reset with all requesters valid.
    #1 rstf = 1'b0; t_valid = '1;
    #1;
    chk("rst_t_ready", 64'(t_ready), 64'h0);
    chk("rst_i_valid", 64'(i_valid), 64'h0);
    chk("rst_i_id", 64'(i_id), 64'h0);
    chk("rst_locked", 64'(locked), 64'h0);
    @(negedge clk);
    rstf = 1'b1; t_last = '1; t_data = {32'hd3, 32'hd2, 32'hd1, 32'hd0};
    step();
    #1;
    chk("rst_first_id", 64'(i_id), 64'h0);
    chk("rst_first_valid", 64'(i_valid), 64'h1);

    // Fairness: back-to-back single-beat packets from everyone.
    do_reset();
    t_valid = '1; t_last = '1;
    idq.delete();
    for (int i = 0; i < 8; i++) begin
      t_data = {32'(i*4+3), 32'(i*4+2), 32'(i*4+1), 32'(i*4)};
      step();
    end
    t_valid = '0;
    step();
    chk("fair_count", 64'(idq.size() >= 8), 64'h1);
    for (int i = 0; i < 8; i++) if (i < idq.size()) chk("fair_id", 64'(idq[i]), 64'(i % 4));

    // Lock: req1 sends 3 beats while req0 and req2 stay valid.
    do_reset();
    idq.delete();
    t_valid = 4'b0001; t_last = 4'b0001; t_data = {32'h2222, 32'h2111, 32'h2000, 32'h1000};
    step();
    t_valid = 4'b0111;
    b = 0;
    for (int c = 0; c < 10 && b < 3; c++) begin
      t_last = (b == 2) ? 4'b0111 : 4'b0101;
      t_data[32 +: 32] = 32'(32'h1100 + b);
      step();
      if (m_xfer == 1) b++;
    end
    step();
    t_valid = '0;
    step();
    chk("lock_count", 64'(idq.size() >= 5), 64'h1);
    for (int i = 0; i < 5; i++) begin
      int exp_id;
      exp_id = (i == 0) ? 0 : (i == 4) ? 2 : 1;
      if (i < idq.size()) chk("lock_id", 64'(idq[i]), 64'(exp_id));
    end

    // Backpressure mid-packet: 4-beat packet from req2, i_ready low for 5 cycles.
    do_reset();
    outq.delete();
    t_valid = 4'b0100;
    b = 0;
    for (int c = 0; c < 40 && b < 4; c++) begin
      t_data[64 +: 32] = 32'(100 + b);
      t_last = (b == 3) ? 4'b0100 : 4'b0000;
      i_ready = !(c >= 2 && c < 7);
      step();
      if (m_xfer == 2) b++;
    end
    t_valid = '0; i_ready = 1'b1;
    step();
    step();
    chk("bp_count", 64'(outq.size()), 64'd4);
    for (int i = 0; i < 4; i++) if (i < outq.size()) chk("bp_data", 64'(outq[i]), 64'(100 + i));

    // Odd NREQ wrap on the 3-requester instance.
    do_reset();
    t_valid3 = 3'b010; t_last3 = 3'b111;
    #1 chk("w3_tr0", 64'(t_ready3), 64'b010);
    @(posedge clk); @(negedge clk);
    t_valid3 = 3'b101;
    #1 chk("w3_tr1", 64'(t_ready3), 64'b100);
    chk("w3_id0", 64'(i_id3), 64'd1);
    @(posedge clk); @(negedge clk);
    #1 chk("w3_tr2", 64'(t_ready3), 64'b001);
    chk("w3_id1", 64'(i_id3), 64'd2);
    @(posedge clk); @(negedge clk);
    #1 chk("w3_tr3", 64'(t_ready3), 64'b100);
    chk("w3_id2", 64'(i_id3), 64'd0);
    @(posedge clk); @(negedge clk);
    #1 chk("w3_id3", 64'(i_id3), 64'd2);
    chk("w3_locked", 64'(locked3), 64'h0);
    t_valid3 = '0;

    // Reset during beat 2 of 4 from req3.
    do_reset();
    t_valid = 4'b1000; i_ready = 1'b1;
    b = 0;
    for (int c = 0; c < 20 && b < 2; c++) begin
      t_data[96 +: 32] = 32'(200 + b);
      t_last = 4'b0000;
      step();
      if (m_xfer == 3) b++;
    end
    t_data[96 +: 32] = 32'd202;
    #1 rstf = 1'b0;
    #1;
    chk("mid_rst_locked", 64'(locked), 64'h0);
    chk("mid_rst_valid", 64'(i_valid), 64'h0);
    chk("mid_rst_tready", 64'(t_ready), 64'h0);
    m_reset();
    @(posedge clk); @(negedge clk);
    rstf = 1'b1; t_valid = '1; t_last = '1;
    step();
    #1 chk("post_rst_id", 64'(i_id), 64'h0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      t_valid = 4'($urandom);
      t_last  = 4'($urandom);
      t_data  = {$urandom, $urandom, $urandom, $urandom};
      i_ready = ($urandom_range(3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
